// File: rtl/test_mode_sequencer.sv
// -----------------------------------------------------------------------------
// test_mode_sequencer
//
// Owns the 2-bit ModeSelect that steers the MICROROC slow-control/data mux
// between ACQ (00), SCurve (01), SweepACQ (10) and None (11), and sequences
// every mode change: drain the USB FIFO, switch the mux, let it settle,
// reload the slow-control parameters, start the selected test engine and wait
// for it to finish or be aborted.
//
// Ports:
//   Clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   ModeRequest      in   [1:0] requested mode, sampled with ModeRequestValid
//   ModeRequestValid in   single-cycle request strobe
//   TestStop         in   USB abort, level-sensitive
//   UsbFifoEmpty     in   USB FIFO empty flag
//   SCLoadDone       in   pulse from the SC shifter when the load completes
//   TestDone         in   pulse from the active test engine
//   ModeSelect       out  [1:0] registered mux select
//   SCParameterLoad  out  one-cycle SC load pulse
//   SC_or_Readreg    out  0 = SC chain, 1 = read register (always 0 here)
//   TestStart        out  one-cycle start pulse to the selected engine
//   Busy             out  high whenever the sequencer is not idle
//   RequestRejected  out  one-cycle pulse for a request seen while busy
//   LoadTimeout      out  sticky error, cleared by the next accepted request
// -----------------------------------------------------------------------------
module test_mode_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOAD_TIMEOUT  = 65535,
  parameter int CNT_W         = 16
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic [1:0] ModeRequest,
  input  logic       ModeRequestValid,
  input  logic       TestStop,
  input  logic       UsbFifoEmpty,
  input  logic       SCLoadDone,
  input  logic       TestDone,
  output logic [1:0] ModeSelect,
  output logic       SCParameterLoad,
  output logic       SC_or_Readreg,
  output logic       TestStart,
  output logic       Busy,
  output logic       RequestRejected,
  output logic       LoadTimeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'b11;

  // Terminal counts are "last cycle in the state", so SETTLE and LOAD each
  // last exactly their parameter's number of cycles.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state;
  logic [1:0]       pending_mode;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment of the shared settle/timeout counter.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // Whole sequencer in one registered block. Pulses default low every cycle
  // and are set only on the transition that fires them, so an abort
  // (TestStop) taking priority automatically suppresses them. TestStop is
  // checked first in every busy state; it parks the mux on None.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      pending_mode    <= MODE_NONE;
      cnt             <= '0;
      ModeSelect      <= MODE_NONE;
      SCParameterLoad <= 1'b0;
      SC_or_Readreg   <= 1'b0;
      TestStart       <= 1'b0;
      Busy            <= 1'b0;
      RequestRejected <= 1'b0;
      LoadTimeout     <= 1'b0;
    end else begin
      SCParameterLoad <= 1'b0;
      TestStart       <= 1'b0;
      RequestRejected <= 1'b0;
      SC_or_Readreg   <= 1'b0;

      // Only a strobe seen in IDLE is accepted; anything else is bounced,
      // including the cycle on which the FSM is heading back to IDLE.
      if (ModeRequestValid && (state != ST_IDLE)) begin
        RequestRejected <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (ModeRequestValid) begin
            pending_mode <= ModeRequest;
            LoadTimeout  <= 1'b0;
            cnt          <= '0;
            Busy         <= 1'b1;
            state        <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (TestStop) begin
            ModeSelect <= MODE_NONE;
            cnt        <= '0;
            Busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (UsbFifoEmpty) begin
            ModeSelect <= pending_mode;
            cnt        <= '0;
            state      <= ST_SETTLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_SETTLE: begin
          if (TestStop) begin
            ModeSelect <= MODE_NONE;
            cnt        <= '0;
            Busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (pending_mode == MODE_NONE) begin
              Busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              SCParameterLoad <= 1'b1;
              state           <= ST_LOAD;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        // SCLoadDone is tested before the timeout so a late-but-coincident
        // completion still starts the test.
        ST_LOAD: begin
          if (TestStop) begin
            ModeSelect <= MODE_NONE;
            cnt        <= '0;
            Busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (SCLoadDone) begin
            TestStart <= 1'b1;
            cnt       <= '0;
            state     <= ST_RUN;
          end else if (cnt == LOAD_LAST) begin
            LoadTimeout <= 1'b1;
            ModeSelect  <= MODE_NONE;
            cnt         <= '0;
            Busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // A normal finish leaves ModeSelect on the test mode so readout of
        // the results is not disturbed.
        ST_RUN: begin
          if (TestStop) begin
            ModeSelect <= MODE_NONE;
            cnt        <= '0;
            Busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (TestDone) begin
            cnt   <= '0;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          ModeSelect <= MODE_NONE;
          cnt        <= '0;
          Busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_test_mode_sequencer
//
// Self-checking bench for test_mode_sequencer with SETTLE_CYCLES=16 and
// LOAD_TIMEOUT=100. A table of stimulus rows drives the inputs, advances a
// given number of clocks and compares every output against hand-computed
// values; a hand-written sequence covers the asynchronous reset in LOAD.
// -----------------------------------------------------------------------------
module tb_test_mode_sequencer;

  logic       Clk;
  logic       reset_n;
  logic [1:0] ModeRequest;
  logic       ModeRequestValid;
  logic       TestStop;
  logic       UsbFifoEmpty;
  logic       SCLoadDone;
  logic       TestDone;
  logic [1:0] ModeSelect;
  logic       SCParameterLoad;
  logic       SC_or_Readreg;
  logic       TestStart;
  logic       Busy;
  logic       RequestRejected;
  logic       LoadTimeout;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic [1:0] req;
    logic       valid;
    logic       stop;
    logic       fifo;
    logic       ldone;
    logic       tdone;
    int         cycles;
    logic [1:0] exp_mode;
    logic       exp_load;
    logic       exp_start;
    logic       exp_busy;
    logic       exp_rej;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];

  test_mode_sequencer #(
    .SETTLE_CYCLES(16),
    .LOAD_TIMEOUT (100),
    .CNT_W        (16)
  ) dut (
    .Clk             (Clk),
    .reset_n         (reset_n),
    .ModeRequest     (ModeRequest),
    .ModeRequestValid(ModeRequestValid),
    .TestStop        (TestStop),
    .UsbFifoEmpty    (UsbFifoEmpty),
    .SCLoadDone      (SCLoadDone),
    .TestDone        (TestDone),
    .ModeSelect      (ModeSelect),
    .SCParameterLoad (SCParameterLoad),
    .SC_or_Readreg   (SC_or_Readreg),
    .TestStart       (TestStart),
    .Busy            (Busy),
    .RequestRejected (RequestRejected),
    .LoadTimeout     (LoadTimeout)
  );

  // 10 ns clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Append one stimulus/expectation row to the table.
  function automatic void add(string name, logic [1:0] req, logic valid,
                              logic stop, logic fifo, logic ldone, logic tdone,
                              int cycles, logic [1:0] exp_mode, logic exp_load,
                              logic exp_start, logic exp_busy, logic exp_rej,
                              logic exp_to);
    vec_t v;
    v.name = name; v.req = req; v.valid = valid; v.stop = stop; v.fifo = fifo;
    v.ldone = ldone; v.tdone = tdone; v.cycles = cycles;
    v.exp_mode = exp_mode; v.exp_load = exp_load; v.exp_start = exp_start;
    v.exp_busy = exp_busy; v.exp_rej = exp_rej; v.exp_to = exp_to;
    vecs.push_back(v);
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input string field,
                             input logic [1:0] actual, input logic [1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, actual, expected);
    end
  endtask

  // Compare every output at once.
  task automatic checkAll(input string name, input logic [1:0] mode,
                          input logic load, input logic start, input logic busy,
                          input logic rej, input logic to);
    checkOutput(name, "ModeSelect", ModeSelect, mode);
    checkOutput(name, "SCParameterLoad", {1'b0, SCParameterLoad}, {1'b0, load});
    checkOutput(name, "TestStart", {1'b0, TestStart}, {1'b0, start});
    checkOutput(name, "Busy", {1'b0, Busy}, {1'b0, busy});
    checkOutput(name, "RequestRejected", {1'b0, RequestRejected}, {1'b0, rej});
    checkOutput(name, "LoadTimeout", {1'b0, LoadTimeout}, {1'b0, to});
    checkOutput(name, "SC_or_Readreg", {1'b0, SC_or_Readreg}, 2'b00);
  endtask

  // Drive a row's inputs, advance its cycle count (strobes only last the
  // first cycle, levels are held) and sample 1 ns after the final edge.
  task automatic applyStimulus(input vec_t v);
    ModeRequest      = v.req;
    ModeRequestValid = v.valid;
    TestStop         = v.stop;
    UsbFifoEmpty     = v.fifo;
    SCLoadDone       = v.ldone;
    TestDone         = v.tdone;
    for (int i = 0; i < v.cycles; i++) begin
      @(posedge Clk);
      #1;
      ModeRequestValid = 1'b0;
      SCLoadDone       = 1'b0;
      TestDone         = 1'b0;
    end
    checkAll(v.name, v.exp_mode, v.exp_load, v.exp_start, v.exp_busy,
             v.exp_rej, v.exp_to);
  endtask

  initial begin
    reset_n          = 1'b0;
    ModeRequest      = 2'b00;
    ModeRequestValid = 1'b0;
    TestStop         = 1'b0;
    UsbFifoEmpty     = 1'b1;
    SCLoadDone       = 1'b0;
    TestDone         = 1'b0;

    //  name           req   v  s  f  ld td cyc  mode  ld st by rj to
    // Mode 01, FIFO empty: ModeSelect at cycle 2, load at cycle 18.
    add("s1_req",      2'b01,1,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("s1_drain",    2'b00,0,0,1, 0,0, 1,  2'b01,0,0,1,0,0);
    add("s1_settle",   2'b00,0,0,1, 0,0, 15, 2'b01,0,0,1,0,0);
    add("s1_load",     2'b00,0,0,1, 0,0, 1,  2'b01,1,0,1,0,0);
    add("s1_load_end", 2'b00,0,0,1, 0,0, 1,  2'b01,0,0,1,0,0);
    add("s1_wait",     2'b00,0,0,1, 0,0, 4,  2'b01,0,0,1,0,0);
    add("s1_ldone",    2'b00,0,0,1, 1,0, 1,  2'b01,0,1,1,0,0);
    add("s1_run",      2'b00,0,0,1, 0,0, 1,  2'b01,0,0,1,0,0);
    add("s1_tdone",    2'b00,0,0,1, 0,1, 1,  2'b01,0,0,0,0,0);
    // Mode 10 with the FIFO busy for 40 cycles, plus a reject during RUN.
    add("s2_req",      2'b10,1,0,0, 0,0, 1,  2'b01,0,0,1,0,0);
    add("s2_fifo",     2'b00,0,0,0, 0,0, 39, 2'b01,0,0,1,0,0);
    add("s2_empty",    2'b00,0,0,1, 0,0, 1,  2'b10,0,0,1,0,0);
    add("s2_settle",   2'b00,0,0,1, 0,0, 15, 2'b10,0,0,1,0,0);
    add("s2_load",     2'b00,0,0,1, 0,0, 1,  2'b10,1,0,1,0,0);
    add("s2_ldone",    2'b00,0,0,1, 1,0, 1,  2'b10,0,1,1,0,0);
    add("s2_reject",   2'b00,1,0,1, 0,0, 1,  2'b10,0,0,1,1,0);
    add("s2_rej_end",  2'b00,0,0,1, 0,0, 1,  2'b10,0,0,1,0,0);
    add("s2_tdone",    2'b00,0,0,1, 0,1, 1,  2'b10,0,0,0,0,0);
    // Load timeout after exactly 100 LOAD cycles; next request clears it,
    // then TestStop mid-SETTLE.
    add("t_req",       2'b01,1,0,1, 0,0, 1,  2'b10,0,0,1,0,0);
    add("t_drain",     2'b00,0,0,1, 0,0, 1,  2'b01,0,0,1,0,0);
    add("t_settle",    2'b00,0,0,1, 0,0, 16, 2'b01,1,0,1,0,0);
    add("t_wait99",    2'b00,0,0,1, 0,0, 99, 2'b01,0,0,1,0,0);
    add("t_expire",    2'b00,0,0,1, 0,0, 1,  2'b11,0,0,0,0,1);
    add("t_sticky",    2'b00,0,0,1, 0,0, 3,  2'b11,0,0,0,0,1);
    add("t_clear",     2'b00,1,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("t_drain2",    2'b00,0,0,1, 0,0, 1,  2'b00,0,0,1,0,0);
    add("t_settle5",   2'b00,0,0,1, 0,0, 5,  2'b00,0,0,1,0,0);
    add("t_stop",      2'b00,0,1,1, 0,0, 1,  2'b11,0,0,0,0,0);
    add("t_stop_idle", 2'b00,0,1,1, 0,0, 2,  2'b11,0,0,0,0,0);
    // TestStop on the last SETTLE cycle suppresses the load pulse.
    add("u_req",       2'b10,1,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("u_drain",     2'b00,0,0,1, 0,0, 1,  2'b10,0,0,1,0,0);
    add("u_settle",    2'b00,0,0,1, 0,0, 15, 2'b10,0,0,1,0,0);
    add("u_stop",      2'b00,0,1,1, 0,0, 1,  2'b11,0,0,0,0,0);
    // SCLoadDone on the timeout cycle wins; TestStop in RUN with a
    // coincident request is rejected and parks the mux.
    add("b_req",       2'b10,1,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("b_drain",     2'b00,0,0,1, 0,0, 1,  2'b10,0,0,1,0,0);
    add("b_settle",    2'b00,0,0,1, 0,0, 16, 2'b10,1,0,1,0,0);
    add("b_wait99",    2'b00,0,0,1, 0,0, 99, 2'b10,0,0,1,0,0);
    add("b_ldone_to",  2'b00,0,0,1, 1,0, 1,  2'b10,0,1,1,0,0);
    add("b_stop_req",  2'b01,1,1,1, 0,0, 1,  2'b11,0,0,0,1,0);
    add("b_release",   2'b00,0,0,1, 0,0, 1,  2'b11,0,0,0,0,0);
    // Mode 11: no load, no start, idle after the settle period.
    add("n_req",       2'b11,1,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("n_drain",     2'b00,0,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("n_settle",    2'b00,0,0,1, 0,0, 15, 2'b11,0,0,1,0,0);
    add("n_end",       2'b00,0,0,1, 0,0, 1,  2'b11,0,0,0,0,0);
    add("n_idle",      2'b00,0,0,1, 0,0, 2,  2'b11,0,0,0,0,0);
    // TestStop together with SCLoadDone suppresses TestStart.
    add("l_req",       2'b01,1,0,1, 0,0, 1,  2'b11,0,0,1,0,0);
    add("l_drain",     2'b00,0,0,1, 0,0, 1,  2'b01,0,0,1,0,0);
    add("l_settle",    2'b00,0,0,1, 0,0, 16, 2'b01,1,0,1,0,0);
    add("l_both",      2'b00,0,1,1, 1,0, 1,  2'b11,0,0,0,0,0);
    add("l_release",   2'b00,0,0,1, 0,0, 1,  2'b11,0,0,0,0,0);

    // Reset state.
    repeat (3) @(posedge Clk);
    #1;
    checkAll("reset_held", 2'b11, 0, 0, 0, 0, 0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checkAll("reset_release", 2'b11, 0, 0, 0, 0, 0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Asynchronous reset while SCParameterLoad is high in LOAD.
    ModeRequest      = 2'b01;
    ModeRequestValid = 1'b1;
    UsbFifoEmpty     = 1'b1;
    TestStop         = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(posedge Clk);
      #1;
      ModeRequestValid = 1'b0;
    end
    checkAll("r_load", 2'b01, 1, 0, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkAll("r_async", 2'b11, 0, 0, 0, 0, 0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checkAll("r_idle", 2'b11, 0, 0, 0, 0, 0);

    // Normal sequence after reset release.
    ModeRequest      = 2'b10;
    ModeRequestValid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(posedge Clk);
      #1;
      ModeRequestValid = 1'b0;
    end
    checkAll("r2_load", 2'b10, 1, 0, 1, 0, 0);
    SCLoadDone = 1'b1;
    @(posedge Clk);
    #1;
    SCLoadDone = 1'b0;
    checkAll("r2_start", 2'b10, 0, 1, 1, 0, 0);
    TestDone = 1'b1;
    @(posedge Clk);
    #1;
    TestDone = 1'b0;
    checkAll("r2_done", 2'b10, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/test_mode_sequencer.md
Name: test_mode_sequencer

Overview:
- Owns the 2-bit ModeSelect that steers the MICROROC slow-control/data mux between ACQ (00), SCurve (01), SweepACQ (10) and None (11).
- Sequences every mode change: drain the USB FIFO, switch the mux, let it settle, reload the slow-control parameters, start the selected test engine, and wait for it to finish or be aborted.
- Sits between the USB command decoder and the mode mux / test engines.

Parameters:
- SETTLE_CYCLES, 16, Clk cycles ModeSelect is held stable before the SC load is issued (≥1).
- LOAD_TIMEOUT, 65535, max Clk cycles to wait for SCLoadDone before abort (≥2).
- CNT_W, 16, width of the shared settle/timeout counter (must hold both values above).

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ModeRequest  in  2  requested mode; sampled only when ModeRequestValid=1.
- ModeRequestValid  in  1  single-cycle request strobe.
- TestStop  in  1  USB abort; level-sensitive, sampled every cycle.
- UsbFifoEmpty  in  1  USB FIFO empty flag.
- SCLoadDone  in  1  one-cycle pulse from the SC shifter when the load is complete.
- TestDone  in  1  one-cycle pulse from the active test engine.
- ModeSelect  out  2  registered mux select.
- SCParameterLoad  out  1  one-cycle SC load pulse.
- SC_or_Readreg  out  1  0 = SC chain, 1 = read register; driven 0 for all modes in this revision.
- TestStart  out  1  one-cycle start pulse to the selected engine.
- Busy  out  1  high in any state other than IDLE.
- RequestRejected  out  1  one-cycle pulse when a request arrives while Busy.
- LoadTimeout  out  1  sticky error flag; cleared by the next accepted request.

Behaviour:
- Reset values: ModeSelect=2'b11, SCParameterLoad=0, SC_or_Readreg=0, TestStart=0, Busy=0, RequestRejected=0, LoadTimeout=0, state=IDLE, counter=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - On ModeRequestValid: latch ModeRequest into a pending register, clear LoadTimeout, go to DRAIN.
  - Busy rises on the cycle after the strobe.
- DRAIN: wait for UsbFifoEmpty=1.
  - Then load ModeSelect with the pending mode, clear the counter, go to SETTLE.
  - ModeSelect changes only on this transition, or when ModeSelect is forced to 11.
- SETTLE: count SETTLE_CYCLES cycles.
  - If the pending mode is 11: return to IDLE (no load, no start).
  - Otherwise: pulse SCParameterLoad for exactly 1 cycle, clear the counter, go to LOAD.
- LOAD: wait for SCLoadDone.
  - On SCLoadDone: pulse TestStart for 1 cycle, go to RUN.
  - If the counter reaches LOAD_TIMEOUT first: set LoadTimeout, force ModeSelect=11, go to IDLE.
  - SCLoadDone arriving on the same cycle as the timeout: SCLoadDone wins.
- RUN: wait for TestDone, or TestStop=1, then go to IDLE.
  - ModeSelect stays at the test mode after a normal finish, so readout is not disturbed.
  - On TestStop it is forced to 11.
- TestStop in DRAIN, SETTLE or LOAD:
  - Go to IDLE next cycle and force ModeSelect=11.
  - Suppress any SCParameterLoad or TestStart pulse that would have fired that cycle.
- Request arriving while Busy (including the cycle the FSM returns to IDLE):
  - Ignored; pulse RequestRejected for 1 cycle.
  - The pending mode and state are unchanged.
  - Only a strobe seen while state=IDLE is accepted.
- Counter: CNT_W-bit, saturating (never wraps), reset on every state entry.
- SETTLE lasts exactly SETTLE_CYCLES cycles, from the first SETTLE cycle to the cycle before the transition.
- Latency, IDLE request to SCParameterLoad with FIFO already empty: 1 (IDLE→DRAIN) + 1 (DRAIN→SETTLE) + SETTLE_CYCLES cycles.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately; no pulse is completed.

Test Plan:
- Reset → ModeSelect=11, Busy=0, all pulses 0; then request mode 01 with FIFO empty → ModeSelect=01 at cycle 2, SCParameterLoad at cycle 18 (SETTLE_CYCLES=16); SCLoadDone 5 cycles later → TestStart the next cycle; TestDone → Busy=0, ModeSelect stays 01.
- Request 10 with UsbFifoEmpty=0 for 40 cycles → ModeSelect unchanged (01) until the FIFO goes empty, then switches to 10; rest of the sequence is as above.
- LOAD_TIMEOUT=100, SCLoadDone never asserted → LoadTimeout=1 exactly 100 cycles after entering LOAD, ModeSelect=11, no TestStart; next request clears LoadTimeout.
- Second ModeRequestValid while in RUN → one RequestRejected pulse, ModeSelect and state unchanged; TestStop during SETTLE → IDLE next cycle, ModeSelect=11, no SCParameterLoad.
- Request 11 → ModeSelect=11, no SCParameterLoad, no TestStart, Busy drops after the settle period.
- Assert reset_n=0 during LOAD → outputs reset asynchronously within the same cycle; after release a new request sequences normally.
